// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start, LSB-first data, optional parity, 1/2 stops.
// Optional line-break drive on break_req when UART_TX_BREAK_EN is defined.
module uart_tx_serializer #(
  parameter int DATA_WIDTH     = 8,
  parameter int BAUD_DIV_WIDTH = 16
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic [BAUD_DIV_WIDTH-1:0] baud_div,
  input  logic                      parity_en,
  input  logic                      two_stop_bits,
  input  logic [DATA_WIDTH:0]       frame_in,
  input  logic                      frame_valid,
`ifdef UART_TX_BREAK_EN
  input  logic                      break_req,
`endif
  output logic                      frame_ready,
  output logic                      tx_out,
  output logic                      busy,
  output logic                      frame_done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam int BIT_W =
    (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT =
    BIT_W'(DATA_WIDTH - 1);

  logic [2:0]                state_q, state_d;
  logic [BAUD_DIV_WIDTH-1:0] baud_cnt_q, baud_cnt_d;
  logic [BIT_W-1:0]          bit_cnt_q, bit_cnt_d;
  logic                      stop_cnt_q, stop_cnt_d;
  logic [DATA_WIDTH-1:0]     shift_q, shift_d;
  logic                      par_q, par_d;
  logic [BAUD_DIV_WIDTH-1:0] div_q, div_d;
  logic                      pen_q, pen_d;
  logic                      two_q, two_d;
  logic                      tx_q, tx_d;
  logic                      ready_q, ready_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  logic accept;
  logic bit_end;
  logic brk;
  logic idle_brk;

`ifdef UART_TX_BREAK_EN
  assign brk = break_req;
`else
  assign brk = 1'b0;
`endif

  assign accept   = frame_valid && ready_q;
  assign bit_end  = (baud_cnt_q == div_q);
  assign idle_brk = brk && (state_q == S_IDLE);

  // Frame sequencing, baud timing and shadow capture
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q + 1'b1;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    div_d      = div_q;
    pen_d      = pen_q;
    two_d      = two_q;
    done_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        baud_cnt_d = '0;
        if (accept) begin
          state_d    = S_START;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          shift_d    = frame_in[DATA_WIDTH-1:0];
          par_d      = frame_in[DATA_WIDTH];
          div_d      = baud_div;
          pen_d      = parity_en;
          two_d      = two_stop_bits;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d    = S_DATA;
          baud_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          shift_d    = shift_q >> 1;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = pen_q ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d    = S_STOP;
          baud_cnt_d = '0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          if (two_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d    = S_IDLE;
        baud_cnt_d = '0;
      end
    endcase
  end

  // Registered line level and handshake outputs from next state
  always_comb begin
    tx_d = 1'b1;
    unique case (1'b1)
      (state_d == S_START):  tx_d = 1'b0;
      (state_d == S_DATA):   tx_d = shift_d[0];
      (state_d == S_PARITY): tx_d = par_d;
      default:               tx_d = 1'b1;
    endcase
    if ((state_d == S_IDLE) && idle_brk) begin
      tx_d = 1'b0;
    end
    ready_d = (state_d == S_IDLE) && !idle_brk;
    busy_d  = !ready_d;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      div_q      <= '0;
      pen_q      <= 1'b0;
      two_q      <= 1'b0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      div_q      <= div_d;
      pen_q      <= pen_d;
      two_q      <= two_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx_out      = tx_q;
  assign frame_ready = ready_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer (default build).
// Frame vectors from a table, plus back-to-back and reset corner cases.
module tb_uart_tx_serializer;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [15:0] baud_div;
  logic        parity_en;
  logic        two_stop_bits;
  logic [8:0]  frame_in;
  logic        frame_valid;
  logic        frame_ready;
  logic        tx_out;
  logic        busy;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;

  uart_tx_serializer #(
    .DATA_WIDTH(8),
    .BAUD_DIV_WIDTH(16)
  ) dut (
    .HCLK(HCLK),
    .HRESET(HRESET),
    .baud_div(baud_div),
    .parity_en(parity_en),
    .two_stop_bits(two_stop_bits),
    .frame_in(frame_in),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .tx_out(tx_out),
    .busy(busy),
    .frame_done(frame_done)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [15:0] div;
    logic        pen;
    logic        two;
    logic [8:0]  frame;
    int          len;
    logic [15:0] seq;
  } vec_t;

  vec_t vecs [4];

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [15:0] seq2;
    logic seen_done;

    vecs[0] = '{div: 16'd3, pen: 1'b1, two: 1'b0,
                frame: 9'h1A5, len: 11, seq: 16'h074A};
    vecs[1] = '{div: 16'd0, pen: 1'b0, two: 1'b1,
                frame: 9'h000, len: 11, seq: 16'h0600};
    vecs[2] = '{div: 16'd2, pen: 1'b1, two: 1'b1,
                frame: 9'h0FF, len: 12, seq: 16'h0DFE};
    vecs[3] = '{div: 16'd1, pen: 1'b0, two: 1'b0,
                frame: 9'h13C, len: 10, seq: 16'h0278};

    HRESET        = 1'b1;
    baud_div      = '0;
    parity_en     = 1'b0;
    two_stop_bits = 1'b0;
    frame_in      = '0;
    frame_valid   = 1'b0;
    repeat (3) tick();
    chk("reset outs", {tx_out, frame_ready, busy, frame_done}, 4'b1100);
    HRESET = 1'b0;

    for (int c = 0; c < 20; c++) begin
      tick();
      chk($sformatf("idle c%0d", c),
          {tx_out, frame_ready, busy, frame_done}, 4'b1100);
    end

    for (int i = 0; i < 4; i++) begin
      chk($sformatf("v%0d ready", i), frame_ready, 1'b1);
      baud_div      = vecs[i].div;
      parity_en     = vecs[i].pen;
      two_stop_bits = vecs[i].two;
      frame_in      = vecs[i].frame;
      frame_valid   = 1'b1;
      tick();
      frame_valid   = 1'b0;
      frame_in      = 9'h0C3;
      baud_div      = 16'd7;
      parity_en     = !vecs[i].pen;
      two_stop_bits = !vecs[i].two;
      for (int b = 0; b < vecs[i].len; b++) begin
        for (int c = 0; c <= int'(vecs[i].div); c++) begin
          chk($sformatf("v%0d b%0d c%0d tx", i, b, c),
              tx_out, vecs[i].seq[b]);
          if (c == 0)
            chk($sformatf("v%0d b%0d ctl", i, b),
                {frame_ready, busy, frame_done}, 3'b010);
          tick();
        end
      end
      chk($sformatf("v%0d done", i),
          {tx_out, frame_ready, busy, frame_done}, 4'b1101);
      tick();
      chk($sformatf("v%0d post", i),
          {tx_out, frame_ready, busy, frame_done}, 4'b1100);
    end

    baud_div      = 16'd1;
    parity_en     = 1'b0;
    two_stop_bits = 1'b0;
    frame_in      = 9'h055;
    frame_valid   = 1'b1;
    tick();
    frame_in = 9'h0AA;
    w = 0;
    while (!frame_done && w < 100) begin
      tick();
      w++;
    end
    chk("b2b first len", w, 20);
    chk("b2b done cyc", {tx_out, frame_ready, busy}, 3'b110);
    tick();
    frame_valid = 1'b0;
    chk("b2b second start", {tx_out, frame_ready, busy, frame_done},
        4'b0010);
    seq2 = 16'h0354;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < 2; c++) begin
        chk($sformatf("b2b b%0d c%0d tx", b, c), tx_out, seq2[b]);
        tick();
      end
    end
    chk("b2b second done", {tx_out, frame_ready, frame_done}, 3'b111);
    tick();

    baud_div    = 16'd3;
    parity_en   = 1'b1;
    frame_in    = 9'h1A5;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    repeat (17) tick();
    chk("rst data bit3", {tx_out, busy}, 2'b01);
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    chk("rst mid outs", {tx_out, frame_ready, busy, frame_done}, 4'b1100);
    seen_done = 1'b0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (frame_done || !tx_out) seen_done = 1'b1;
    end
    chk("rst no done", seen_done, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
